priority_arbiter_4: RTL and testbench

PRIORITY_ARBITER_4 -- requirements
Module: priority_arbiter_4

---
 rtl/priority_arbiter_4_pkg.sv | 17 +
 rtl/priority_arbiter_4_prio_pick.sv | 27 ++
 rtl/priority_arbiter_4.sv | 104 ++++++++++
 tb/tb_priority_arbiter_4.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/priority_arbiter_4_pkg.sv
// Shared types and constants for the 4-way priority arbiter.
package priority_arbiter_4_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/priority_arbiter_4_prio_pick.sv
// Combinational rotated-priority picker: searches downward from start, wrapping.
module prio_pick_4
    import priority_arbiter_4_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            // 2-bit subtraction wraps naturally modulo 4
            cand = start - IDX_W'(k);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/priority_arbiter_4.sv
// 4-way arbiter with fixed / round-robin priority, hold limit and one-cycle release gap.
module priority_arbiter_4
    import priority_arbiter_4_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] done,
    input  logic       rr_mode,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

    state_t             state, state_next;
    logic [IDX_W-1:0]   owner, owner_next;
    logic [7:0]         hold_cnt, hold_next;
    logic [NUM_REQ-1:0] gnt_next;
    logic [IDX_W-1:0]   id_next;
    logic               valid_next;
    logic               timeout_next;

    logic [IDX_W-1:0]   pick_start;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    // owner doubles as the round-robin pointer: the last granted index
    assign pick_start = rr_mode ? owner + 2'd3 : 2'd3;

    prio_pick_4 u_pick (
        .req   (req),
        .start (pick_start),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        state_next   = state;
        owner_next   = owner;
        hold_next    = hold_cnt;
        gnt_next     = '0;
        id_next      = '0;
        valid_next   = 1'b0;
        timeout_next = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_next = GRANT;
                    owner_next = pick_idx;
                    hold_next  = '0;
                    gnt_next   = onehot(pick_idx);
                    id_next    = pick_idx;
                    valid_next = 1'b1;
                end
            end
            GRANT: begin
                hold_next = hold_cnt + 8'd1;
                // a voluntary release wins over the hold limit in the same cycle
                if (!req[owner] || done[owner]) begin
                    state_next = RELEASE;
                end else if (hold_cnt == HOLD_LIMIT) begin
                    state_next   = RELEASE;
                    timeout_next = 1'b1;
                end else begin
                    gnt_next   = onehot(owner);
                    id_next    = owner;
                    valid_next = 1'b1;
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_next;
            owner     <= owner_next;
            hold_cnt  <= hold_next;
            gnt       <= gnt_next;
            gnt_id    <= id_next;
            gnt_valid <= valid_next;
            timeout   <= timeout_next;
        end
    end

endmodule

// File: tb/tb_priority_arbiter_4.sv
// Directed plus randomized bench for priority_arbiter_4 against a behavioural model.
module tb_priority_arbiter_4;

    localparam int TB_MAX_HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] done;
    logic       rr_mode;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // behavioural model: who owns the bus, for how long, and the post-release gap
    int m_owner = -1;
    int m_held  = 0;
    int m_gap   = 0;
    int m_last  = 0;
    bit m_to    = 1'b0;

    priority_arbiter_4 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .rr_mode   (rr_mode),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_gap   = 0;
        m_last  = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step();
        int start;
        int win;
        int c;
        if (m_owner >= 0) begin
            m_held++;
            if (!req[m_owner] || done[m_owner]) begin
                m_owner = -1; m_gap = 1; m_to = 1'b0;
            end else if (m_held == TB_MAX_HOLD) begin
                m_owner = -1; m_gap = 1; m_to = 1'b1;
            end
        end else if (m_gap > 0) begin
            m_gap = 0;
            m_to  = 1'b0;
        end else begin
            m_to = 1'b0;
            if (req != 4'b0000) begin
                start = rr_mode ? (m_last + 3) % 4 : 3;
                win = -1;
                for (int k = 0; k < 4; k++) begin
                    c = (start - k + 4) % 4;
                    if (win < 0 && req[c]) win = c;
                end
                m_owner = win;
                m_last  = win;
                m_held  = 0;
            end
        end
    endtask

    task automatic check_model();
        logic [3:0] eg;
        eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("gnt_id", 32'(gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        chk("timeout", 32'(timeout), 32'(m_to));
        chk("onehot", 32'($onehot0(gnt)), 32'd1);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_id", 32'(gnt_id), 32'd0);
        chk("rst_valid", 32'(gnt_valid), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        int order [5];
        order = '{3, 2, 1, 0, 3};
        req = '0; done = '0; rr_mode = 1'b0; rst_n = 1'b0;
        do_reset();

        // fixed priority
        rr_mode = 1'b0; req = 4'b1011;
        tick(); chk("fix_gnt3", 32'(gnt), 32'h8); chk("fix_id3", 32'(gnt_id), 32'd3);
        tick(); chk("fix_hold", 32'(gnt), 32'h8);
        req = 4'b0011;
        tick(); chk("fix_rel", 32'(gnt), 32'h0);
        tick(); chk("fix_idle", 32'(gnt), 32'h0);
        tick(); chk("fix_gnt1", 32'(gnt), 32'h2);
        req = 4'b0000;
        tick(); tick();

        // round robin with done strobes
        do_reset();
        rr_mode = 1'b1; req = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("rr_gnt", 32'(gnt), 32'(1 << order[i]));
            if (i < 4) begin
                done = 4'(1 << order[i]);
                tick(); chk("rr_gap1", 32'(gnt), 32'h0);
                done = 4'b0000;
                tick(); chk("rr_gap2", 32'(gnt), 32'h0);
                tick();
            end
        end
        done = 4'b1000; req = 4'b0000;
        tick(); done = 4'b0000; tick();

        // hold-limit timeout
        do_reset();
        rr_mode = 1'b0; req = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            tick(); chk("to_hold", 32'(gnt), 32'h4); chk("to_quiet", 32'(timeout), 32'd0);
        end
        tick(); chk("to_gnt0", 32'(gnt), 32'h0); chk("to_pulse", 32'(timeout), 32'd1);
        tick(); chk("to_pulse_end", 32'(timeout), 32'd0); chk("to_gap", 32'(gnt), 32'h0);
        tick(); chk("to_regrant", 32'(gnt), 32'h4);

        // done at the hold limit: release without timeout
        tick(); tick(); tick();
        done = 4'b0100;
        tick(); chk("sim_gnt0", 32'(gnt), 32'h0); chk("sim_noto", 32'(timeout), 32'd0);
        done = 4'b0000; req = 4'b0000;
        tick(); tick();

        // done from a non-owner is ignored
        req = 4'b1000;
        tick(); chk("nod_gnt3", 32'(gnt), 32'h8);
        done = 4'b0010;
        tick(); chk("nod_keep", 32'(gnt), 32'h8);
        done = 4'b0000; req = 4'b0000;
        tick(); tick();

        // asynchronous reset in the middle of a grant
        req = 4'b0010;
        tick(); chk("mid_gnt1", 32'(gnt), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'h0);
        chk("mid_rst_valid", 32'(gnt_valid), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1; req = 4'b0001;
        tick(); chk("mid_regrant", 32'(gnt), 32'h1);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            req     = 4'($urandom_range(0, 15));
            done    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            rr_mode = 1'($urandom_range(0, 1));
            if (n % 97 == 96) do_reset();
            else tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
